// File: rtl/frame_max_tracker.sv
// Aligns the address generator's enable/address with a synchronous memory's read latency,
// forwards samples as a valid/first/last stream and reports the signed maximum of each frame.
module frame_max_tracker #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              data_first,
    output logic              data_last,
    output logic [DATA_W-1:0] max_out,
    output logic              max_valid,
    output logic [15:0]       frame_count
);

    localparam logic signed [DATA_W-1:0] ACC_RESET = {1'b1, {(DATA_W-1){1'b0}}};

    // Each stage lives in its own generate scope so every register has exactly one driver.
    genvar gi;
    generate
        for (gi = 0; gi < READ_LATENCY; gi++) begin : g_stage
            logic              valid_reg;
            logic [ADDR_W-1:0] addr_reg;
            if (gi == 0) begin : g_head
                always_ff @(posedge clock or posedge reset) begin
                    if (reset) begin
                        valid_reg <= 1'b0;
                        addr_reg  <= '0;
                    end else begin
                        valid_reg <= en;
                        addr_reg  <= address;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clock or posedge reset) begin
                    if (reset) begin
                        valid_reg <= 1'b0;
                        addr_reg  <= '0;
                    end else begin
                        valid_reg <= g_stage[gi-1].valid_reg;
                        addr_reg  <= g_stage[gi-1].addr_reg;
                    end
                end
            end
        end
    endgenerate

    logic                     dv;
    logic [ADDR_W-1:0]        da;
    logic                     frame_start;
    logic                     frame_end;
    logic signed [DATA_W-1:0] sample;
    logic signed [DATA_W-1:0] acc_reg;
    logic signed [DATA_W-1:0] acc_next;

    assign dv          = g_stage[READ_LATENCY-1].valid_reg;
    assign da          = g_stage[READ_LATENCY-1].addr_reg;
    assign frame_start = (da == '0);
    assign frame_end   = (da == '1);
    assign sample      = $signed(rd_data);

    // Address 0 restarts the accumulator so a partial frame never leaks into the next one.
    always_comb begin
        acc_next = acc_reg;
        if (frame_start) begin
            acc_next = sample;
        end else if (sample > acc_reg) begin
            acc_next = sample;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_out    <= '0;
            data_valid  <= 1'b0;
            data_first  <= 1'b0;
            data_last   <= 1'b0;
            acc_reg     <= ACC_RESET;
            max_out     <= '0;
            max_valid   <= 1'b0;
            frame_count <= '0;
        end else begin
            data_valid <= dv;
            data_first <= dv && frame_start;
            data_last  <= dv && frame_end;
            max_valid  <= dv && frame_end;
            if (dv) begin
                data_out <= rd_data;
                acc_reg  <= acc_next;
                if (frame_end) begin
                    max_out     <= acc_next;
                    frame_count <= frame_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_max_tracker.sv
// Bench for frame_max_tracker: three instances (read latency 2, 1, 4) share one stimulus stream,
// a cycle-scheduled sample model checks every cycle, plus hand-computed frame results.
module tb_frame_max_tracker;

    localparam int AW   = 10;
    localparam int NF   = 1024;
    localparam int NDUT = 3;

    typedef struct packed {
        logic        v;
        logic        f;
        logic        l;
        logic        mv;
        logic [15:0] data;
        logic [15:0] mx;
        logic [15:0] fc;
    } obs_t;

    logic          clock;
    logic          reset;
    logic          en;
    logic [AW-1:0] address;
    logic [1:0]    bank;

    logic [15:0] mem [4][NF];
    logic [15:0] rdp [4];

    logic [15:0] d_out  [NDUT];
    logic        d_valid[NDUT];
    logic        d_first[NDUT];
    logic        d_last [NDUT];
    logic [15:0] d_max  [NDUT];
    logic        d_mv   [NDUT];
    logic [15:0] d_fc   [NDUT];

    int checks = 0;
    int errors = 0;

    function automatic int lat_of(input int d);
        case (d)
            0:       return 2;
            1:       return 1;
            default: return 4;
        endcase
    endfunction

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Synchronous memory: rdp[i] is the word addressed i+1 cycles ago.
    always @(posedge clock) begin
        rdp[0] <= mem[bank][address];
        for (int i = 1; i < 4; i++) rdp[i] <= rdp[i-1];
    end

    frame_max_tracker #(.DATA_W(16), .ADDR_W(AW), .READ_LATENCY(2)) u_dut0 (
        .clock(clock), .reset(reset), .en(en), .address(address), .rd_data(rdp[1]),
        .data_out(d_out[0]), .data_valid(d_valid[0]), .data_first(d_first[0]),
        .data_last(d_last[0]), .max_out(d_max[0]), .max_valid(d_mv[0]), .frame_count(d_fc[0]));

    frame_max_tracker #(.DATA_W(16), .ADDR_W(AW), .READ_LATENCY(1)) u_dut1 (
        .clock(clock), .reset(reset), .en(en), .address(address), .rd_data(rdp[0]),
        .data_out(d_out[1]), .data_valid(d_valid[1]), .data_first(d_first[1]),
        .data_last(d_last[1]), .max_out(d_max[1]), .max_valid(d_mv[1]), .frame_count(d_fc[1]));

    frame_max_tracker #(.DATA_W(16), .ADDR_W(AW), .READ_LATENCY(4)) u_dut2 (
        .clock(clock), .reset(reset), .en(en), .address(address), .rd_data(rdp[3]),
        .data_out(d_out[2]), .data_valid(d_valid[2]), .data_first(d_first[2]),
        .data_last(d_last[2]), .max_out(d_max[2]), .max_valid(d_mv[2]), .frame_count(d_fc[2]));

    // Model: each issued read becomes a sample record due on the output lat+1 cycles later.
    obs_t ring  [NDUT][8];
    bit   ring_v[NDUT][8];
    obs_t vis   [NDUT];
    int   j = 0;
    logic signed [15:0] m_acc;
    logic [15:0]        m_max;
    logic [15:0]        m_fc;

    always @(posedge clock) begin
        logic signed [15:0] s;
        obs_t e;
        j = j + 1;
        if (reset) begin
            for (int d = 0; d < NDUT; d++) begin
                vis[d] = '0;
                for (int k = 0; k < 8; k++) ring_v[d][k] = 1'b0;
            end
            m_acc = -16'sd32768;
            m_max = '0;
            m_fc  = '0;
        end else begin
            for (int d = 0; d < NDUT; d++) begin
                vis[d].v  = 1'b0;
                vis[d].f  = 1'b0;
                vis[d].l  = 1'b0;
                vis[d].mv = 1'b0;
                if (ring_v[d][j % 8]) begin
                    vis[d] = ring[d][j % 8];
                    ring_v[d][j % 8] = 1'b0;
                end
            end
            if (en) begin
                s = $signed(mem[bank][address]);
                if (address == 0 || s > m_acc) m_acc = s;
                e.v    = 1'b1;
                e.f    = (address == 0);
                e.l    = (address == NF - 1);
                e.mv   = e.l;
                e.data = s;
                if (e.l) begin
                    m_max = m_acc;
                    m_fc  = m_fc + 16'd1;
                end
                e.mx = m_max;
                e.fc = m_fc;
                for (int d = 0; d < NDUT; d++) begin
                    ring[d][(j + lat_of(d)) % 8]   = e;
                    ring_v[d][(j + lat_of(d)) % 8] = 1'b1;
                end
            end
        end
    end

    // Observations of instance 0 for the hand-computed checks.
    int          first_j;
    int          last_j;
    int          vcount;
    int          mvj  [$];
    logic [15:0] mvmax[$];
    logic [15:0] mvfc [$];

    task automatic clr_mon();
        first_j = -1;
        last_j  = -1;
        vcount  = 0;
        mvj.delete();
        mvmax.delete();
        mvfc.delete();
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic compare_loop();
        obs_t act;
        obs_t exp;
        forever begin
            @(negedge clock);
            if (j >= 1) begin
                for (int d = 0; d < NDUT; d++) begin
                    act.v = d_valid[d]; act.f = d_first[d]; act.l = d_last[d]; act.mv = d_mv[d];
                    act.data = d_out[d]; act.mx = d_max[d]; act.fc = d_fc[d];
                    exp = reset ? '0 : vis[d];
                    checks++;
                    if (act !== exp) begin
                        errors++;
                        $display("FAIL cycle_dut%0d j=%0d actual v%b f%b l%b mv%b data %h max %h fc %0d required v%b f%b l%b mv%b data %h max %h fc %0d",
                                 d, j, act.v, act.f, act.l, act.mv, act.data, act.mx, act.fc,
                                 exp.v, exp.f, exp.l, exp.mv, exp.data, exp.mx, exp.fc);
                    end
                end
                if (d_valid[0]) vcount++;
                if (d_valid[0] && d_first[0] && first_j < 0) first_j = j;
                if (d_valid[0] && d_last[0]) last_j = j;
                if (d_mv[0]) begin
                    mvj.push_back(j);
                    mvmax.push_back(d_max[0]);
                    mvfc.push_back(d_fc[0]);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input bit e, input int a, input int b);
        en      = e;
        address = a[AW-1:0];
        bank    = b[1:0];
        tick();
    endtask

    task automatic drain();
        en = 1'b0;
        repeat (8) tick();
    endtask

    task automatic stream(input int b);
        for (int a = 0; a < NF; a++) drive(1'b1, a, b);
    endtask

    int lat_seen[NDUT];

    initial begin
        reset   = 1'b1;
        en      = 1'b0;
        address = '0;
        bank    = '0;
        for (int a = 0; a < NF; a++) begin
            mem[0][a] = 16'(a - 1000);
            mem[1][a] = 16'hfffb;
            mem[2][a] = 16'h8000;
            mem[3][a] = '0;
        end
        mem[1][0]    = 16'h7fff;
        mem[2][1023] = 16'd100;
        clr_mon();
        fork
            compare_loop();
        join_none

        repeat (3) tick();
        chk("reset_valid", int'(d_valid[0]), 0);
        chk("reset_max", int'(d_max[0]), 0);
        chk("reset_fc", int'(d_fc[2]), 0);
        reset = 1'b0;
        repeat (2) tick();

        // Continuous frame of address-1000: maximum is 1023-1000 = 23.
        clr_mon();
        stream(0);
        drain();
        chk("cont_first_to_last", last_j - first_j, 1023);
        chk("cont_mv_count", mvj.size(), 1);
        if (mvj.size() == 1) begin
            chk("cont_mv_with_last", mvj[0], last_j);
            chk("cont_max", int'($signed(mvmax[0])), 23);
            chk("cont_fc", int'(mvfc[0]), 1);
        end

        // Maxima sitting on the first and on the last sample.
        clr_mon();
        stream(1);
        drain();
        stream(2);
        drain();
        chk("bound_mv_count", mvj.size(), 2);
        if (mvj.size() == 2) begin
            chk("bound_max_first", int'($signed(mvmax[0])), 32767);
            chk("bound_max_last", int'($signed(mvmax[1])), 100);
            chk("bound_fc", int'(mvfc[1]), 3);
        end

        // Bubble on every other cycle.
        clr_mon();
        for (int a = 0; a < NF; a++) begin
            drive(1'b1, a, 0);
            drive(1'b0, a, 0);
        end
        drain();
        chk("bubble_valid_count", vcount, NF);
        chk("bubble_mv_count", mvj.size(), 1);
        if (mvj.size() == 1) chk("bubble_max", int'($signed(mvmax[0])), 23);

        // Single read at address 0: first valid appears lat+1 cycles later.
        for (int d = 0; d < NDUT; d++) lat_seen[d] = -1;
        en      = 1'b1;
        address = '0;
        bank    = 2'd0;
        tick();
        en = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            for (int d = 0; d < NDUT; d++)
                if (lat_seen[d] < 0 && d_valid[d] && d_first[d]) lat_seen[d] = k;
            tick();
        end
        chk("lat2_cycles", lat_seen[0], 3);
        chk("lat1_cycles", lat_seen[1], 2);
        chk("lat4_cycles", lat_seen[2], 5);
        drain();

        // Reset in the middle of a frame while samples are streaming.
        for (int a = 0; a < 60; a++) drive(1'b1, a, 0);
        reset = 1'b1;
        en    = 1'b0;
        #1;
        chk("async_valid", int'(d_valid[0]), 0);
        chk("async_data", int'(d_out[0]), 0);
        chk("async_fc", int'(d_fc[0]), 0);
        chk("async_data_lat4", int'(d_out[2]), 0);
        repeat (2) tick();
        reset = 1'b0;
        clr_mon();
        repeat (12) tick();
        chk("post_reset_mv_count", mvj.size(), 0);
        chk("post_reset_fc", int'(d_fc[1]), 0);

        // Three back-to-back frames with maxima -7, 0, 4095.
        for (int a = 0; a < NF; a++) begin
            mem[1][a] = 16'hffec;
            mem[2][a] = 16'hff9c;
            mem[3][a] = 16'(a);
        end
        mem[1][500] = 16'hfff9;
        mem[2][3]   = 16'h0000;
        mem[3][700] = 16'd4095;
        clr_mon();
        stream(1);
        stream(2);
        stream(3);
        drain();
        chk("b2b_mv_count", mvj.size(), 3);
        if (mvj.size() == 3) begin
            chk("b2b_gap1", mvj[1] - mvj[0], 1024);
            chk("b2b_gap2", mvj[2] - mvj[1], 1024);
            chk("b2b_max1", int'($signed(mvmax[0])), -7);
            chk("b2b_max2", int'($signed(mvmax[1])), 0);
            chk("b2b_max3", int'($signed(mvmax[2])), 4095);
            chk("b2b_fc1", int'(mvfc[0]), 1);
            chk("b2b_fc2", int'(mvfc[1]), 2);
            chk("b2b_fc3", int'(mvfc[2]), 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_max_tracker.md
# frame_max_tracker

Downstream stage of the 1024-entry address generator in the pipelined softmax datapath. It takes the generator's enable and address in parallel with the synchronous input memory, aligns them with the memory's read latency, and forwards the read samples as a valid/last stream. It also computes the signed maximum of each 1024-sample frame, which the exponent stage needs for max-subtraction.

## Interface
Parameters:
- DATA_W, 16, width of signed two's-complement samples read from memory
- ADDR_W, 10, address width; frame length is 2^ADDR_W samples
- READ_LATENCY, 2, cycles from address presented to rd_data valid; legal range 1..4

Ports:
- clock  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- en  input  1  same enable that advances the address generator; high means a read is issued this cycle
- address  input  ADDR_W  address presented to memory this cycle
- rd_data  input  DATA_W  memory read data, valid READ_LATENCY cycles after its address
- data_out  output  DATA_W  aligned sample
- data_valid  output  1  data_out holds a sample this cycle
- data_first  output  1  sample is address 0 of a frame; qualified by data_valid
- data_last  output  1  sample is address 2^ADDR_W-1; qualified by data_valid
- max_out  output  DATA_W  signed maximum of the most recently completed frame
- max_valid  output  1  one-cycle pulse when max_out updates
- frame_count  output  16  number of completed frames; wraps from 65535 to 0

## Operation
- Alignment pipe: a shift register of depth READ_LATENCY carries {en, address}. Its output stage is the "delayed valid" (dv) and the "delayed address" (da).
- data_out is rd_data captured when dv is high. It holds its last value otherwise.
- data_valid = dv. data_first = dv and da==0. data_last = dv and da==all-ones. All three are registered together with data_out.
- Running max acc, signed compare:
  - dv with da==0: acc <= rd_data unconditionally. This starts a new frame and discards any partial frame.
  - dv with da!=0: acc <= max(acc, rd_data).
- Frame close (dv with da==all-ones):
  - max_out <= max(acc, rd_data), so the final sample is included.
  - max_valid pulses high.
  - frame_count increments.
- Frame with 2^ADDR_W==1 cannot occur (ADDR_W>=1). For a one-sample-long run the rules above already apply.
- Gaps: en low creates bubbles. The pipe shifts every cycle regardless of en, so bubbles propagate and acc is unaffected. A frame may span any number of bubbles.
- Missed frame start: if sampling begins mid-frame (first dv with da!=0), acc is compared against its reset value. The resulting max_out is defined but not meaningful. Downstream uses data_first to qualify.

## Timing
- Reset (async assert, synchronous release by the system) sets:
  - pipe valids = 0, data_out = 0, data_valid/first/last = 0
  - acc = most-negative value (-2^(DATA_W-1)), max_out = 0, max_valid = 0, frame_count = 0
- Latency: en/address at cycle t produces data_valid at cycle t+READ_LATENCY+1 (one output register stage).
- max_valid asserts in the same cycle as data_last for the closing sample.
- max_out and frame_count change only on max_valid and hold between frames.
- Reset mid-frame: everything in flight is dropped. No max_valid is produced for the interrupted frame, and the pipe restarts empty.
- Throughput: one sample per cycle, with no backpressure. The consumer must accept every data_valid.

## Test plan
- Reset mid-stream: assert reset while data_valid is high. Outputs must go to 0 asynchronously (before the next edge), frame_count=0, and no spurious max_valid may appear after release.
- Continuous frame, en held high for 1024 cycles, memory contents = address-1000 (signed). Required: data_first at first valid, data_last 1023 valid-cycles later, max_valid in the same cycle as data_last with max_out=23, frame_count=1.
- Max at boundaries, frame with sample[0]=+32767 and all others -5: max_out=32767. Then a frame with sample[1023]=+100 and all others -32768: max_out=100.
- Bubbles: toggle en every other cycle across a full frame. data_valid pattern must match en delayed by READ_LATENCY+1, and max_out must equal the bubble-free result.
- Latency sweep: READ_LATENCY=1 and 4, single en pulse at address 0. data_valid and data_first must appear exactly 2 and 5 cycles later respectively.
- Back-to-back frames ×3 with different maxima (-7, 0, 4095): three max_valid pulses exactly 1024 cycles apart, frame_count 1, 2, 3, and the second frame's max must not see the first frame's data.
